instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Parametrised instruction sequencer that replaces hand-timed instruction delivery to the processor `top`. It holds a small program of fixed-width instruction words loaded through a write port. On `start` it presents the words to the core one at a time, each for a fixed dwell time or until the core handshakes. It stops on an end-of-file word (all zeros) or at the end of the loaded program, drives the EOF instruction, and reports halt status.

## Interface
- `WIDTH`, 16: instruction word width in bits.
- `DEPTH`, 16: program capacity in words; must be a power of two, ≥2.
- `HOLD_CYCLES`, 8: cycles each word is presented in timed mode; ≥1.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `clear`  in  1: synchronous return to IDLE; empties the program.
- `wr_en`  in  1: append `wr_data` to the program (IDLE only).
- `wr_data`  in  WIDTH: instruction word to append.
- `wr_full`  out  1: program holds DEPTH words.
- `start`  in  1: begin issuing (IDLE only).
- `instr_ready`  in  1: core accepted current word (handshake mode only).
- `instruction`  out  WIDTH: registered instruction to the core.
- `instr_valid`  out  1: `instruction` holds a program word.
- `busy`  out  1: state is ISSUE.
- `halted`  out  1: state is HALT.
- `pc`  out  $clog2(DEPTH): index of the word being presented.
- `count`  out  $clog2(DEPTH)+1: number of words loaded.

## Operation
- States are IDLE, ISSUE and HALT.
- **Reset values (on `rst`=0):** state IDLE, `instruction`=0, `instr_valid`=0, `busy`=0, `halted`=0, `wr_full`=0, `pc`=0, `count`=0, dwell counter 0.
- **IDLE:**
  - `wr_en` with `count`<DEPTH writes mem[count], then `count`+1.
  - `wr_en` while full is dropped; no state change.
  - `start` with `count`>0 goes to ISSUE with `pc`=0.
  - `start` with `count`=0 goes straight to HALT.
- **ISSUE:**
  - `instruction`=mem[pc] and `instr_valid`=1.
  - The word advances when the advance condition fires (see Configuration).
  - On advance, if `pc`+1 = `count`, go to HALT; otherwise increment `pc` and reload the dwell counter.
  - If the word about to be loaded into `instruction` is all zeros, the sequencer enters HALT instead of presenting it. The embedded EOF terminates the program.
- **HALT:**
  - `instruction`=0 (EOF), `instr_valid`=0, `halted`=1.
  - The sequencer stays in HALT until `clear`.
  - Program contents are retained only until `clear`.
- **clear:** from any state, go to IDLE next cycle with `pc`=0, `count`=0 and `instruction`=0.
  - `clear` has priority over `start` and `wr_en` in the same cycle.
- **Ignored inputs:**
  - `wr_en` outside IDLE is ignored.
  - `start` outside IDLE is ignored.
- **Simultaneous `wr_en` and `start` in IDLE:** the write is accepted and included in the program run.
- **Storage:** memory is plain registers and is not reset. `count` alone defines valid content.

## Timing
- `start` sampled high at edge N: `instruction`=mem[0] and `instr_valid`=1 from edge N+1.
- Timed mode: each word is visible for exactly HOLD_CYCLES cycles, back to back, with no bubble.
- After the last word's final cycle, `halted`=1 and `instruction`=0 at the next edge.
- `wr_full` updates the cycle after the write that fills the program.
- An asynchronous `rst` assertion mid-ISSUE forces reset values immediately, with no completion of the current word.

## Configuration
- Macro: `INSTR_SEQ_HANDSHAKE_EN`.
- **Defined:** a word advances on the first cycle with `instr_valid`=1 and `instr_ready`=1. HOLD_CYCLES is unused. A word with `instr_ready` held high is presented for exactly 1 cycle.
- **Undefined:** `instr_ready` is ignored. A word advances when the dwell counter expires after HOLD_CYCLES cycles.

## Test plan
- **Timed run:** load 0x4142, 0x4402, 0x0253, 0x0291, start, using HOLD_CYCLES=8.
  - Each word holds 8 cycles, in order, with `pc` 0..3.
  - At cycle 33 after start, `halted`=1 and `instruction`=0x0000.
- **Embedded EOF:** load 0x0253, 0x0000, 0x0291.
  - 0x0253 is shown for 8 cycles, then HALT.
  - 0x0291 is never presented.
- **Full/empty:**
  - 17 writes with DEPTH=16: `wr_full`=1 after the 16th, the 17th is dropped, `count`=16.
  - `start` with `count`=0 gives HALT next cycle with `instr_valid` never high.
- **Control precedence:**
  - `clear` asserted at pc=2 mid-ISSUE gives IDLE, `count`=0, `instruction`=0 next cycle.
  - `start` and `clear` together leave the sequencer in IDLE.
- **Handshake (macro defined):** load 0x02D2, 0x0312; hold `instr_ready` low 3 cycles, then high.
  - 0x02D2 is held 4 cycles.
  - 0x0312 then advances after 1 cycle with `instr_ready` high.
- **Async reset:** `rst` low mid-word gives all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Brief    : Holds a small program of instruction words loaded through a
//            write port and presents them to the core one at a time, then
//            parks on the EOF (all-zero) instruction and reports halt.
//            Build option INSTR_SEQ_HANDSHAKE_EN: advance on instr_ready
//            instead of a fixed HOLD_CYCLES dwell time.
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 16,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     wr_full,
    input  logic                     start,
    input  logic                     instr_ready,
    output logic [WIDTH-1:0]         instruction,
    output logic                     instr_valid,
    output logic                     busy,
    output logic                     halted,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PC_W    = $clog2(DEPTH);
    localparam int c_CNT_W   = c_PC_W + 1;
    localparam int c_DWELL_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [c_CNT_W-1:0]   c_DEPTH_CNT  = c_CNT_W'(DEPTH);
    localparam logic [c_DWELL_W-1:0] c_DWELL_LOAD = c_DWELL_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [WIDTH-1:0]     r_instr;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_halted;
    logic                 r_wr_full;
    logic [c_PC_W-1:0]    r_pc;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_DWELL_W-1:0] r_dwell;

    logic                 w_wr_accept;
    logic                 w_empty_run;
    logic                 w_last;
    logic                 w_advance;
    logic [WIDTH-1:0]     w_first_word;
    logic [WIDTH-1:0]     w_next_word;
    logic [c_PC_W-1:0]    w_pc_next;

    // Writes land only in IDLE, only while space remains, and lose to clear.
    assign w_wr_accept  = (r_state == S_IDLE) && !clear && wr_en && (r_count < c_DEPTH_CNT);

    // A write in the same cycle as start joins the run; with an empty
    // program that write is the first word, so bypass the memory.
    assign w_empty_run  = (r_count == '0) && !w_wr_accept;
    assign w_first_word = (r_count == '0) ? wr_data : r_mem[0];

    assign w_pc_next    = r_pc + c_PC_W'(1);
    assign w_last       = ({1'b0, r_pc} + c_CNT_W'(1)) == r_count;
    assign w_next_word  = r_mem[w_pc_next];

`ifdef INSTR_SEQ_HANDSHAKE_EN
    assign w_advance = r_valid && instr_ready;
    logic w_unused_dwell;
    assign w_unused_dwell = &{1'b0, r_dwell};
`else
    assign w_advance = (r_dwell == '0);
    logic w_unused_ready;
    assign w_unused_ready = instr_ready;
`endif

    // Program storage: plain registers, no reset; count defines valid content.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_count[c_PC_W-1:0]] <= wr_data;
        end
    end

    // Sequencer control: state, presented word, program counter and flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_instr   <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
            r_wr_full <= 1'b0;
            r_pc      <= '0;
            r_count   <= '0;
            r_dwell   <= '0;
        end else if (clear) begin
            r_state   <= S_IDLE;
            r_instr   <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
            r_wr_full <= 1'b0;
            r_pc      <= '0;
            r_count   <= '0;
            r_dwell   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_accept) begin
                        r_count   <= r_count + c_CNT_W'(1);
                        r_wr_full <= (r_count + c_CNT_W'(1)) == c_DEPTH_CNT;
                    end
                    if (start) begin
                        r_pc <= '0;
                        if (w_empty_run || (w_first_word == '0)) begin
                            // Nothing to present: park on EOF straight away.
                            r_state  <= S_HALT;
                            r_instr  <= '0;
                            r_valid  <= 1'b0;
                            r_busy   <= 1'b0;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                            r_instr <= w_first_word;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                            r_dwell <= c_DWELL_LOAD;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_advance) begin
                        if (w_last || (w_next_word == '0)) begin
                            // End of program or embedded EOF: never show it.
                            r_state  <= S_HALT;
                            r_instr  <= '0;
                            r_valid  <= 1'b0;
                            r_busy   <= 1'b0;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc    <= w_pc_next;
                            r_instr <= w_next_word;
                            r_dwell <= c_DWELL_LOAD;
                        end
                    end else begin
                        r_dwell <= r_dwell - c_DWELL_W'(1);
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign instruction = r_instr;
    assign instr_valid = r_valid;
    assign busy        = r_busy;
    assign halted      = r_halted;
    assign wr_full     = r_wr_full;
    assign pc          = r_pc;
    assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Brief    : Self-checking bench for instr_sequencer. A queue holds the
//            accepted program; the expected word stream is derived from it
//            (words up to the first zero, each shown for the dwell time or
//            until a handshake) and compared cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int HOLD  = 8;
    localparam int MAXC  = 4000;

    logic             clk         = 1'b0;
    logic             rst         = 1'b1;
    logic             clear       = 1'b0;
    logic             wr_en       = 1'b0;
    logic [WIDTH-1:0] wr_data     = '0;
    logic             start       = 1'b0;
    logic             instr_ready = 1'b0;
    logic             wr_full;
    logic [WIDTH-1:0] instruction;
    logic             instr_valid;
    logic             busy;
    logic             halted;
    logic [3:0]       pc;
    logic [4:0]       count;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] prog[$];

    instr_sequencer #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_full     (wr_full),
        .start       (start),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .busy        (busy),
        .halted      (halted),
        .pc          (pc),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] rnd_word(input bit allow_zero);
        if (allow_zero && ($urandom_range(0, 5) == 0)) return '0;
        return WIDTH'($urandom_range(1, 65535));
    endfunction

    task automatic load(input logic [WIDTH-1:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        tick();
        wr_en   = 1'b0;
        if (prog.size() < DEPTH) prog.push_back(w);
        chk("load count", 64'(count), 64'(prog.size()));
        chk("load wr_full", 64'(wr_full), 64'(prog.size() == DEPTH));
    endtask

    task automatic do_clear(input string tag);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        prog.delete();
        chk({tag, " clr flags"}, 64'({halted, busy, instr_valid, instruction, wr_full}), 64'(0));
        chk({tag, " clr count"}, 64'(count), 64'(0));
        chk({tag, " clr pc"}, 64'(pc), 64'(0));
    endtask

    // Start the loaded program and follow it to HALT (or to a clear).
    task automatic run_prog(input string tag, input int ready_low, input int clear_at,
                            input bit with_wr, input logic [WIDTH-1:0] wr_word);
        int eff_len;
        int idx;
        int dwell;
        bit rdy;
        bit done;
        if (with_wr) begin
            wr_en   = 1'b1;
            wr_data = wr_word;
            if (prog.size() < DEPTH) prog.push_back(wr_word);
        end
        eff_len = 0;
        while ((eff_len < prog.size()) && (prog[eff_len] != '0)) eff_len++;
        idx   = 0;
        dwell = HOLD;
        done  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        for (int k = 0; (k < MAXC) && !done; k++) begin
            if (idx < eff_len) begin
                chk({tag, " word"}, 64'({halted, busy, instr_valid, instruction}),
                    64'({1'b0, 1'b1, 1'b1, prog[idx]}));
                chk({tag, " pc"}, 64'(pc), 64'(idx));
                if (idx == clear_at) begin
                    do_clear(tag);
                    done = 1'b1;
                end
            end else begin
                chk({tag, " halt"}, 64'({halted, busy, instr_valid, instruction}),
                    64'({1'b1, 1'b0, 1'b0, 16'h0000}));
                done = 1'b1;
            end
            if (!done) begin
                rdy = (ready_low < 0) ? 1'($urandom_range(0, 1)) : (k >= ready_low);
                instr_ready = rdy;
                tick();
`ifdef INSTR_SEQ_HANDSHAKE_EN
                if (rdy) idx++;
`else
                dwell--;
                if (dwell == 0) begin
                    idx++;
                    dwell = HOLD;
                end
`endif
            end
        end
        instr_ready = 1'b0;
        chk({tag, " finished in budget"}, 64'(done), 64'(1));
    endtask

    initial begin
        int len;

        // Reset values
        rst = 1'b0;
        repeat (2) tick();
        chk("reset outputs", 64'({instruction, instr_valid, busy, halted, wr_full, pc, count}), 64'(0));
        rst = 1'b1;
        tick();

        // Timed run from the test plan (ready toggles randomly, ignored when timed)
        load(16'h4142);
        load(16'h4402);
        load(16'h0253);
        load(16'h0291);
        run_prog("plan run", -1, -1, 1'b0, '0);

        // In HALT, writes and start are ignored
        wr_en   = 1'b1;
        wr_data = 16'h1234;
        start   = 1'b1;
        tick();
        wr_en   = 1'b0;
        start   = 1'b0;
        chk("halt ignores", 64'({halted, busy, instr_valid, instruction}), 64'({1'b1, 1'b0, 1'b0, 16'h0}));
        chk("halt count", 64'(count), 64'(prog.size()));

        // Embedded EOF
        do_clear("to eof");
        load(16'h0253);
        load(16'h0000);
        load(16'h0291);
        run_prog("eof run", -1, -1, 1'b0, '0);

        // Full program, 17th write dropped
        do_clear("to full");
        for (int i = 0; i < DEPTH + 1; i++) load(rnd_word(1'b0));
        run_prog("full run", -1, -1, 1'b0, '0);

        // Start with an empty program
        do_clear("to empty");
        run_prog("empty run", -1, -1, 1'b0, '0);

        // Clear mid-issue at pc=2
        do_clear("to midclr");
        for (int i = 0; i < 4; i++) load(rnd_word(1'b0));
        run_prog("midclr run", -1, 2, 1'b0, '0);

        // Start and clear together stay in IDLE
        load(16'h1111);
        load(16'h2222);
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        prog.delete();
        chk("start+clear", 64'({halted, busy, instr_valid, instruction, count}), 64'(0));
        tick();
        chk("start+clear hold", 64'({halted, busy, instr_valid}), 64'(0));

        // Write in the start cycle joins the run
        load(16'h0A0A);
        load(16'h0B0B);
        run_prog("wr+start", -1, -1, 1'b1, 16'h0C0C);
        do_clear("to wr0");
        run_prog("wr+start empty", -1, -1, 1'b1, 16'h0D0D);

`ifdef INSTR_SEQ_HANDSHAKE_EN
        // Handshake plan: ready low 3 cycles, then high
        do_clear("to hs");
        load(16'h02D2);
        load(16'h0312);
        run_prog("hs run", 3, -1, 1'b0, '0);
`endif

        // Randomised programs, occasional embedded zeros
        for (int r = 0; r < 5; r++) begin
            do_clear("to rand");
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < len; i++) load(rnd_word(1'b1));
            run_prog("rand run", -1, -1, 1'b0, '0);
        end

        // Asynchronous reset in the middle of a word
        do_clear("to arst");
        load(16'h7001);
        load(16'h7002);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("arst pre busy", 64'({busy, instruction}), 64'({1'b1, 16'h7001}));
        #2;
        rst = 1'b0;
        #1;
        chk("arst outputs", 64'({instruction, instr_valid, busy, halted, wr_full, pc, count}), 64'(0));
        #3;
        rst = 1'b1;
        prog.delete();
        tick();
        chk("arst after", 64'({halted, busy, instr_valid, count}), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
